// File: rtl/pipeline_irq_ctrl.sv
// Interrupt front-end for the pipeline: synchronise, debounce and edge-latch two external lines,
// then present one masked, prioritised request under a request/ack/eret handshake.
module pipeline_irq_ctrl #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk_gl,
    input  logic       rst,
    input  logic [1:0] irq_raw,
    input  logic [1:0] irq_mask,
    input  logic       irq_ack,
    input  logic       irq_eret,
    output logic [1:0] interrupt,
    output logic [1:0] irq_pending,
    output logic       irq_busy,
    output logic [7:0] irq_drop_cnt
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    logic [1:0] rise;

    for (genvar i = 0; i < 2; i++) begin : g_line
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CNT_W-1:0]       cnt_q;
        logic                   lvl_q;
        logic                   s;
        logic                   differ;
        logic                   accept;

        assign s      = sync_q[SYNC_STAGES-1];
        assign differ = (s != lvl_q);
        // A change is accepted on the cycle the counter has already seen DEBOUNCE_CYCLES-1 mismatches.
        assign accept = differ && (cnt_q == CNT_MAX);
        assign rise[i] = accept && s;

        always_ff @(posedge clk_gl or negedge rst) begin
            if (!rst) begin
                sync_q <= '0;
                cnt_q  <= '0;
                lvl_q  <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], irq_raw[i]};
                if (!differ || accept) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                if (accept) begin
                    lvl_q <= s;
                end
            end
        end
    end

    logic [1:0] state_q, state_d;
    logic [1:0] interrupt_q, interrupt_d;
    logic       busy_q, busy_d;
    logic [1:0] pending_q, pending_d;
    logic [7:0] drop_q, drop_d;
    logic [1:0] clr;
    logic [1:0] req;
    logic [1:0] drop;
    logic [1:0] drop_add;
    logic [8:0] drop_sum;

    assign req = pending_q & irq_mask;

    always_comb begin
        state_d     = state_q;
        interrupt_d = interrupt_q;
        busy_d      = busy_q;
        clr         = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d     = ST_REQ;
                    interrupt_d = req[0] ? 2'b01 : 2'b10;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    state_d     = ST_SERVICE;
                    interrupt_d = 2'b00;
                    busy_d      = 1'b1;
                    clr         = interrupt_q;
                end else if (~|(interrupt_q & irq_mask)) begin
                    // Granted line masked off before ack: withdraw, keep it pending.
                    state_d     = ST_IDLE;
                    interrupt_d = 2'b00;
                end
            end
            ST_SERVICE: begin
                if (irq_eret) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                interrupt_d = 2'b00;
                busy_d      = 1'b0;
            end
        endcase
    end

    // A rise coinciding with its own clear re-sets the flag and is not a lost edge.
    assign pending_d = (pending_q & ~clr) | rise;
    assign drop      = rise & pending_q & ~clr;
    assign drop_add  = {1'b0, drop[0]} + {1'b0, drop[1]};
    assign drop_sum  = {1'b0, drop_q} + {7'b0, drop_add};
    assign drop_d    = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    always_ff @(posedge clk_gl or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            interrupt_q <= 2'b00;
            busy_q      <= 1'b0;
            pending_q   <= 2'b00;
            drop_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            interrupt_q <= interrupt_d;
            busy_q      <= busy_d;
            pending_q   <= pending_d;
            drop_q      <= drop_d;
        end
    end

    assign interrupt    = interrupt_q;
    assign irq_pending  = pending_q;
    assign irq_busy     = busy_q;
    assign irq_drop_cnt = drop_q;

endmodule
